bpsk_bit_framer: RTL

- Upstream stage of the BPSK modulator top. Accepts payload bytes over a valid/ready stream and builds the frame: preamble, sync word, length byte, then payload.
- Serializes the frame MSB-first, one bit per symbol period of SAMPLES_PER_BIT clocks.
- bit_out drives the modulator `in` input; bit_valid drives the modulator `en` input. Symbol boundaries therefore align to whole carrier periods.

---
 rtl/bpsk_bit_framer.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/bpsk_bit_framer.sv
// Purpose : BPSK frame builder. Sends preamble, sync word, length byte, payload
//           (and CRC-8 when BPSK_FRAMER_CRC8_EN is defined), MSB-first, one bit
//           per SAMPLES_PER_BIT clocks.
// Latency : the first preamble bit is on bit_out in the cycle after start is
//           accepted. done pulses in the cycle after the last bit period ends.
// Backpressure: s_ready is high only while busy, the holding byte is empty and
//           fewer than len bytes have been accepted. If a payload byte is
//           missing at its boundary, the frame aborts with an underrun pulse.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   start, len       frame request (sampled in IDLE only), payload byte count
//   s_data/s_valid/s_ready   payload byte stream (valid/ready)
//   bit_out, bit_valid       serial bit and enable toward the modulator
//   busy, done, underrun     frame status; done/underrun are 1-cycle pulses
//
// Optional macro: BPSK_FRAMER_CRC8_EN appends CRC-8 (poly 0x07, init 0x00)
// computed over the length byte and the payload bytes.
// SAMPLES_PER_BIT should be a whole multiple of the modulator carrier period,
// so that phase flips land on carrier-period boundaries.

module bpsk_bit_framer #(
  parameter int          SAMPLES_PER_BIT = 64,
  parameter logic [15:0] PREAMBLE        = 16'hAAAA,
  parameter int          PREAMBLE_BITS   = 16,
  parameter logic [7:0]  SYNC_WORD       = 8'hE5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] len,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam int             SCW         = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
  localparam logic [SCW-1:0] SAMPLE_LAST = SCW'(SAMPLES_PER_BIT - 1);
  // The preamble occupies the low PREAMBLE_BITS bits of PREAMBLE. It is
  // left-justified here so every field shifts out of bit 15.
  localparam logic [15:0]    PRE_ALIGNED = PREAMBLE << (16 - PREAMBLE_BITS);
  localparam logic [3:0]     PRE_LAST    = 4'(PREAMBLE_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SYNC,
    S_LENGTH,
    S_PAYLOAD
`ifdef BPSK_FRAMER_CRC8_EN
    , S_CRC
`endif
  } state_t;

  state_t         state_q, state_d;
  logic [SCW-1:0] sample_cnt;
  logic [3:0]     bit_cnt;         // bits left in the current field, minus one
  logic [15:0]    shift_q;
  logic [7:0]     len_q;
  logic [7:0]     hold_q;
  logic           hold_full;
  logic [8:0]     bytes_accepted;
  logic [8:0]     bytes_sent;
  logic           done_q;
  logic           underrun_q;

  logic           bit_end;
  logic           field_end;
  logic           payload_left;
  logic           load_en;
  logic [15:0]    load_val;
  logic [3:0]     load_last;
  logic           pop_hold;
  logic           fire_done;
  logic           fire_underrun;
  logic           xfer;

`ifdef BPSK_FRAMER_CRC8_EN
  logic [7:0] crc_q;

  // Fold one byte into the running CRC, MSB-first.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc ^ d;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction
`endif

  assign bit_end      = (sample_cnt == SAMPLE_LAST);
  assign field_end    = bit_end && (bit_cnt == 4'd0);
  assign payload_left = (bytes_sent < {1'b0, len_q});

  assign busy      = (state_q != S_IDLE);
  assign bit_valid = busy;
  assign bit_out   = busy & shift_q[15];
  assign s_ready   = busy && !hold_full && (bytes_accepted < {1'b0, len_q});
  assign done      = done_q;
  assign underrun  = underrun_q;
  assign xfer      = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    load_en       = 1'b0;
    load_val      = 16'h0000;
    load_last     = 4'd7;
    pop_hold      = 1'b0;
    fire_done     = 1'b0;
    fire_underrun = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_PREAMBLE;
          load_en   = 1'b1;
          load_val  = PRE_ALIGNED;
          load_last = PRE_LAST;
        end
      end
      S_PREAMBLE: begin
        if (field_end) begin
          state_d  = S_SYNC;
          load_en  = 1'b1;
          load_val = {SYNC_WORD, 8'h00};
        end
      end
      S_SYNC: begin
        if (field_end) begin
          state_d  = S_LENGTH;
          load_en  = 1'b1;
          load_val = {len_q, 8'h00};
        end
      end
      S_LENGTH, S_PAYLOAD: begin
        if (field_end) begin
          if (payload_left) begin
            // A byte boundary: the next byte must already be waiting in hold.
            if (hold_full) begin
              state_d  = S_PAYLOAD;
              load_en  = 1'b1;
              load_val = {hold_q, 8'h00};
              pop_hold = 1'b1;
            end else begin
              state_d       = S_IDLE;
              fire_underrun = 1'b1;
            end
          end else begin
`ifdef BPSK_FRAMER_CRC8_EN
            state_d  = S_CRC;
            load_en  = 1'b1;
            load_val = {crc_q, 8'h00};
`else
            state_d   = S_IDLE;
            fire_done = 1'b1;
`endif
          end
        end
      end
`ifdef BPSK_FRAMER_CRC8_EN
      S_CRC: begin
        if (field_end) begin
          state_d   = S_IDLE;
          fire_done = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cnt     <= '0;
      bit_cnt        <= 4'd0;
      shift_q        <= 16'h0000;
      len_q          <= 8'h00;
      hold_q         <= 8'h00;
      hold_full      <= 1'b0;
      bytes_accepted <= 9'd0;
      bytes_sent     <= 9'd0;
      done_q         <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      done_q     <= fire_done;
      underrun_q <= fire_underrun;

      if (state_q == S_IDLE) sample_cnt <= '0;
      else if (bit_end)      sample_cnt <= '0;
      else                   sample_cnt <= sample_cnt + 1'b1;

      if (load_en) begin
        shift_q <= load_val;
        bit_cnt <= load_last;
      end else if (bit_end) begin
        shift_q <= {shift_q[14:0], 1'b0};
        bit_cnt <= bit_cnt - 1'b1;
      end

      // pop and xfer are mutually exclusive: s_ready needs an empty hold.
      if (pop_hold) begin
        hold_full  <= 1'b0;
        bytes_sent <= bytes_sent + 9'd1;
      end else if (xfer) begin
        hold_q         <= s_data;
        hold_full      <= 1'b1;
        bytes_accepted <= bytes_accepted + 9'd1;
      end

      if (state_q == S_IDLE && start) begin
        len_q          <= len;
        hold_full      <= 1'b0;
        bytes_accepted <= 9'd0;
        bytes_sent     <= 9'd0;
      end
    end
  end

`ifdef BPSK_FRAMER_CRC8_EN
  // The CRC advances as each covered byte is loaded for transmission.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= 8'h00;
    end else if (state_q == S_IDLE && start) begin
      crc_q <= 8'h00;
    end else if (state_q == S_SYNC && field_end) begin
      crc_q <= crc8_byte(crc_q, len_q);
    end else if (pop_hold) begin
      crc_q <= crc8_byte(crc_q, hold_q);
    end
  end
`endif

endmodule
